piso_stream_ser: RTL and testbench

Parametrised parallel-in/serial-out serialiser. It is the successor to the fixed 4-bit PISO shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out one bit per shift_en pulse, with selectable bit order.
- Supports gap-free back-to-back words.
- Flags the final bit of each frame.
- Sits between a parallel producer and a serial line driver.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_shreg.sv | 37 +++
 rtl/piso_stream_ser.sv | 118 +++++++++++
 tb/tb_piso_stream_ser.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the piso_stream_ser serialiser: FSM state encodings
// and the bit-counter width helper.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// WIDTH-bit load/shift register; shifts toward the selected output end and
// zero-fills behind the departing bit.
module piso_shreg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign bit_o = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: rtl/piso_stream_ser.sv
// Parallel-in/serial-out stream serialiser with valid/ready input and
// gap-free back-to-back frames. Define PISO_STREAM_SER_PARITY_EN to append an even-parity bit.
module piso_stream_ser
    import piso_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             out,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            in_shift;
    logic            data_done;
    logic            frame_done;
    logic            load;
    logic            sh_bit;

    assign in_shift  = (state_q == ST_SHIFT);
    assign data_done = in_shift && (cnt_q == LAST) && shift_en;

`ifdef PISO_STREAM_SER_PARITY_EN
    logic parity_q;
    assign frame_done = (state_q == ST_PARITY) && shift_en;
`else
    assign frame_done = data_done;
`endif

    // in_ready opens in the very cycle the final bit is consumed so the next
    // word can follow without an idle gap.
    assign in_ready = rst && ((state_q == ST_IDLE) || frame_done);
    assign load     = in_valid && in_ready;

    piso_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk_i   (clk),
        .rst_n_i (rst),
        .load_i  (load),
        .shift_i (in_shift && shift_en),
        .data_i  (in_data),
        .bit_o   (sh_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
`ifdef PISO_STREAM_SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (load) begin
            state_q  <= ST_SHIFT;
            cnt_q    <= '0;
`ifdef PISO_STREAM_SER_PARITY_EN
            parity_q <= ^in_data;
`endif
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_SHIFT: begin
                    if (data_done) begin
                        cnt_q <= '0;
`ifdef PISO_STREAM_SER_PARITY_EN
                        state_q <= ST_PARITY;
`else
                        state_q <= ST_IDLE;
`endif
                    end else if (shift_en) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (shift_en) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out = IDLE_LEVEL;
        if (in_shift) begin
            out = sh_bit;
        end
`ifdef PISO_STREAM_SER_PARITY_EN
        if (state_q == ST_PARITY) begin
            out = parity_q;
        end
`endif
    end

    assign out_valid = (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
`ifdef PISO_STREAM_SER_PARITY_EN
    assign out_last  = (state_q == ST_PARITY);
`else
    assign out_last  = in_shift && (cnt_q == LAST);
`endif

endmodule

// File: tb/tb_piso_stream_ser.sv
// Self-checking bench: an MSB-first and an LSB-first instance share stimulus
// and are compared each cycle against a queue-of-bits frame model.
module tb_piso_stream_ser;

    localparam int W = 4;

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         in_valid = 1'b0;
    logic         shift_en = 1'b0;
    logic [W-1:0] in_data  = '0;

    logic rdy_m, out_m, ov_m, ol_m, busy_m;
    logic rdy_l, out_l, ov_l, ol_l, busy_l;

    int    total  = 0;
    int    passes = 0;
    bit    acc    = 1'b0;
    string phase  = "reset";

    logic qm[$];
    logic ql[$];

    always #5 clk = ~clk;

    piso_stream_ser #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .shift_en(shift_en), .out(out_m),
        .out_valid(ov_m), .out_last(ol_m), .busy(busy_m)
    );

    piso_stream_ser #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .shift_en(shift_en), .out(out_l),
        .out_valid(ov_l), .out_last(ol_l), .busy(busy_l)
    );

    task automatic chk(input string name, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b at %0t", name, obs, exp, $time);
    endtask

    task automatic check_dut(input string tag, input logic idle_lv, input int sz,
                             input logic front, input logic o, input logic ov,
                             input logic ol, input logic b, input logic r);
        logic exp_r;
        exp_r = rst && ((sz == 0) || ((sz == 1) && shift_en));
        chk({tag, ".out"},       o,  (sz > 0) ? front : idle_lv);
        chk({tag, ".out_valid"}, ov, sz > 0);
        chk({tag, ".out_last"},  ol, sz == 1);
        chk({tag, ".busy"},      b,  sz > 0);
        chk({tag, ".in_ready"},  r,  exp_r);
    endtask

    task automatic check_all();
        logic fm, fl;
        fm = (qm.size() > 0) ? qm[0] : 1'b0;
        fl = (ql.size() > 0) ? ql[0] : 1'b0;
        check_dut({phase, "/msb"}, 1'b0, qm.size(), fm, out_m, ov_m, ol_m, busy_m, rdy_m);
        check_dut({phase, "/lsb"}, 1'b1, ql.size(), fl, out_l, ov_l, ol_l, busy_l, rdy_l);
    endtask

    // One rising edge of the reference: retire the current bit, then accept a word.
    task automatic model_edge();
        bit rdy;
        rdy = rst && ((qm.size() == 0) || ((qm.size() == 1) && shift_en));
        acc = in_valid && rdy;
        if ((qm.size() > 0) && shift_en) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
        if (acc) begin
            for (int i = W - 1; i >= 0; i--) qm.push_back(in_data[i]);
            for (int i = 0; i < W; i++)      ql.push_back(in_data[i]);
`ifdef PISO_STREAM_SER_PARITY_EN
            qm.push_back(^in_data);
            ql.push_back(^in_data);
`endif
        end
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic se);
        in_valid = v;
        in_data  = d;
        shift_en = se;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic se);
        int n = 0;
        do begin
            cyc(1'b1, d, se);
            n++;
        end while (!acc && n < 40);
        total++;
        assert (acc) passes++;
        else $error("FAIL %s.accept_timeout: observed not-accepted expected accepted within 40 cycles", phase);
    endtask

    initial begin
        logic [W-1:0] pd;
        bit           pend;

        #2;
        check_all();
        @(posedge clk);
        #1 rst = 1'b1;

        phase = "single";
        send(4'b1011, 1'b1);
        repeat (5) cyc(1'b0, '0, 1'b1);

        phase = "b2b";
        send(4'b1010, 1'b1);
        send(4'b0110, 1'b1);
        repeat (5) cyc(1'b0, '0, 1'b1);

        phase = "slow";
        send(4'b1100, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b0, '0, (i % 3) == 2);
        repeat (2) cyc(1'b0, '0, 1'b1);

        phase = "arst";
        send(4'b1001, 1'b1);
        repeat (2) cyc(1'b0, '0, 1'b1);
        #2 rst = 1'b0;
        qm.delete();
        ql.delete();
        #1;
        check_all();
        @(posedge clk);
        #1 rst = 1'b1;
        phase = "post_rst";
        send(4'b0110, 1'b1);
        repeat (5) cyc(1'b0, '0, 1'b1);

        phase = "random";
        pend = 1'b0;
        pd   = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && ($urandom_range(0, 2) == 0)) begin
                pend = 1'b1;
                pd   = W'($urandom);
            end
            cyc(pend, pend ? pd : W'($urandom), 1'($urandom_range(0, 1)));
            if (acc) pend = 1'b0;
        end
        repeat (12) cyc(1'b0, '0, 1'b1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
